// File: rtl/bin_to_7seg.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_7seg
// Brief    : Sequential binary-to-4-digit-BCD converter (double dabble) with
//            registered active-low 7-segment digit outputs.
//            Optional build macro BLANK_LEADING_ZEROS_EN blanks leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_7seg #(
  parameter int DATA_BITS = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] bin_in,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [6:0]           digit_0_out,
  output logic [6:0]           digit_1_out,
  output logic [6:0]           digit_2_out,
  output logic [6:0]           digit_3_out
);

  localparam int       CNT_W       = $clog2(DATA_BITS + 1);
  localparam logic [6:0] C_SEG_BLANK = 7'b1111111;
  localparam logic [6:0] C_SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [15:0]          r_bcd;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf_pending;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overflow;
  logic [6:0]           r_dig0, r_dig1, r_dig2, r_dig3;

  logic [15:0]          w_bcd_adj;
  logic                 w_too_big;
  logic [6:0]           w_seg0, w_seg1, w_seg2, w_seg3;

  function automatic logic [6:0] seg_encode(input logic [3:0] n);
    case (n)
      4'd0:    seg_encode = 7'b1000000;
      4'd1:    seg_encode = 7'b1111001;
      4'd2:    seg_encode = 7'b0100100;
      4'd3:    seg_encode = 7'b0110000;
      4'd4:    seg_encode = 7'b0011001;
      4'd5:    seg_encode = 7'b0010010;
      4'd6:    seg_encode = 7'b0000010;
      4'd7:    seg_encode = 7'b1111000;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0010000;
      default: seg_encode = C_SEG_BLANK;
    endcase
  endfunction

  assign w_too_big = {{(32-DATA_BITS){1'b0}}, bin_in} > 32'd9999;

  // Add-3 correction applied to every nibble before each shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_seg0 = seg_encode(r_bcd[3:0]);
    w_seg1 = seg_encode(r_bcd[7:4]);
    w_seg2 = seg_encode(r_bcd[11:8]);
    w_seg3 = seg_encode(r_bcd[15:12]);
`ifdef BLANK_LEADING_ZEROS_EN
    if (r_bcd[15:12] == 4'd0) w_seg3 = C_SEG_BLANK;
    if (r_bcd[15:8]  == 8'd0) w_seg2 = C_SEG_BLANK;
    if (r_bcd[15:4]  == 12'd0) w_seg1 = C_SEG_BLANK;
`endif
    if (r_ovf_pending) begin
      w_seg0 = C_SEG_DASH;
      w_seg1 = C_SEG_DASH;
      w_seg2 = C_SEG_DASH;
      w_seg3 = C_SEG_DASH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_bcd         <= '0;
      r_cnt         <= '0;
      r_ovf_pending <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_dig0        <= C_SEG_BLANK;
      r_dig1        <= C_SEG_BLANK;
      r_dig2        <= C_SEG_BLANK;
      r_dig3        <= C_SEG_BLANK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift       <= bin_in;
            r_bcd         <= '0;
            r_cnt         <= CNT_W'(DATA_BITS);
            r_ovf_pending <= w_too_big;
            r_busy        <= 1'b1;
            r_state       <= S_CONV;
          end
        end
        S_CONV: begin
          // A carry out of the thousands nibble can only come from a value
          // above 9999, so it simply reinforces the overflow flag.
          {r_bcd, r_shift} <= {w_bcd_adj[14:0], r_shift, 1'b0};
          r_ovf_pending    <= r_ovf_pending | w_bcd_adj[15];
          r_cnt            <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1))
            r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_dig0     <= w_seg0;
          r_dig1     <= w_seg1;
          r_dig2     <= w_seg2;
          r_dig3     <= w_seg3;
          r_overflow <= r_ovf_pending;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign overflow    = r_overflow;
  assign digit_0_out = r_dig0;
  assign digit_1_out = r_dig1;
  assign digit_2_out = r_dig2;
  assign digit_3_out = r_dig3;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_7seg.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_7seg
// Brief    : Self-checking bench for bin_to_7seg against a decimal-arithmetic
//            reference model (honours BLANK_LEADING_ZEROS_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_7seg;

  localparam int DATA_BITS = 14;
  localparam int LAT       = DATA_BITS + 2;
  localparam logic [27:0] C_ALL_BLANK = {4{7'b1111111}};

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DATA_BITS-1:0] bin_in;
  logic                 start;
  logic                 busy, done, overflow;
  logic [6:0]           digit_0_out, digit_1_out, digit_2_out, digit_3_out;
  logic [27:0]          digs;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [27:0] prev_digits;
  logic        prev_ovf;

  bin_to_7seg #(.DATA_BITS(DATA_BITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bin_in      (bin_in),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .digit_0_out (digit_0_out),
    .digit_1_out (digit_1_out),
    .digit_2_out (digit_2_out),
    .digit_3_out (digit_3_out)
  );

  always #5 clk = ~clk;

  assign digs = {digit_3_out, digit_2_out, digit_1_out, digit_0_out};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] model_digits(input int v);
    logic [27:0] r;
    logic [6:0]  s;
    int          d[4];
`ifdef BLANK_LEADING_ZEROS_EN
    bit          lead;
    lead = 1'b1;
`endif
    if (v > 9999) return {4{7'b0111111}};
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = v / 1000;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      s = seg_of(d[i]);
`ifdef BLANK_LEADING_ZEROS_EN
      if (lead && d[i] == 0 && i != 0) s = 7'b1111111;
      if (d[i] != 0) lead = 1'b0;
`endif
      r[7*i +: 7] = s;
    end
    return r;
  endfunction

  // Caller has set start/bin_in; the next edge is the acceptance edge.
  task automatic conv_cycles(input int v, input int intr_k, input int intr_v,
                             input int next_v, input bit hold);
    logic [27:0] exp_d;
    exp_d = model_digits(v);
    @(posedge clk); #1;
    for (int k = 1; k <= LAT; k++) begin
      if (k == 1) begin
        if (hold) bin_in = DATA_BITS'(next_v);
        else      start  = 1'b0;
      end
      if (intr_k != 0 && k == intr_k) begin
        start  = 1'b1;
        bin_in = DATA_BITS'(intr_v);
      end
      if (intr_k != 0 && k == intr_k + 1) start = 1'b0;
      check("busy", busy, k < LAT);
      check("done", done, k == LAT);
      if (k < LAT) begin
        check("digits_stable", digs, prev_digits);
        check("ovf_stable", overflow, prev_ovf);
        @(posedge clk); #1;
      end else begin
        check("digits", digs, exp_d);
        check("overflow", overflow, v > 9999);
      end
    end
    prev_digits = exp_d;
    prev_ovf    = (v > 9999);
  endtask

  task automatic run_one(input int v, input int intr_k, input int intr_v);
    bin_in = DATA_BITS'(v);
    start  = 1'b1;
    conv_cycles(v, intr_k, intr_v, 0, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_done", done, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_digits", digs, prev_digits);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int vals[6];
    int v;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_digits", digs, C_ALL_BLANK);
    rst = 1'b0;
    prev_digits = C_ALL_BLANK;
    prev_ovf    = 1'b0;
    idle_cycles(2);

    run_one(1234, 0, 0);
    idle_cycles(1);
    run_one(9999, 0, 0);
    run_one(10000, 0, 0);
    idle_cycles(1);

    // Reset in the middle of a conversion
    bin_in = DATA_BITS'(1234);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_ovf", overflow, 1'b0);
    check("midrst_digits", digs, C_ALL_BLANK);
    @(posedge clk); #1;
    rst = 1'b0;
    prev_digits = C_ALL_BLANK;
    prev_ovf    = 1'b0;
    idle_cycles(LAT + 2);

    run_one(0, 0, 0);
    run_one(105, 0, 0);

    // Second start while busy must be dropped, not queued
    run_one(4321, 2, 777);
    idle_cycles(LAT + 2);

    // start held high: back-to-back conversions, bin_in stepping
    bin_in = DATA_BITS'(1);
    start  = 1'b1;
    conv_cycles(1, 0, 0, 2, 1'b1);
    conv_cycles(2, 0, 0, 3, 1'b1);
    conv_cycles(3, 0, 0, 0, 1'b0);
    idle_cycles(2);

    for (int j = 0; j < 30; j++) begin
      if (j % 3 == 0) v = int'($urandom_range(9990, 10010));
      else            v = int'($urandom_range(0, (1 << DATA_BITS) - 1));
      if (j % 5 == 4) run_one(v, int'($urandom_range(2, LAT - 2)),
                              int'($urandom_range(0, (1 << DATA_BITS) - 1)));
      else            run_one(v, 0, 0);
      if (j % 4 == 0) idle_cycles(1);
    end

    for (int j = 0; j < 6; j++) vals[j] = int'($urandom_range(0, (1 << DATA_BITS) - 1));
    bin_in = DATA_BITS'(vals[0]);
    start  = 1'b1;
    for (int j = 0; j < 6; j++)
      conv_cycles(vals[j], 0, 0, (j < 5) ? vals[j+1] : 0, j < 5);
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin_to_7seg.md
Name: bin_to_7seg

Overview:
- Sequential binary-to-4-digit-decimal converter feeding the 4-digit multiplexed display driver in the pulse-adder design.
- Takes an unsigned count and converts it to BCD with an iterative shift-add-3 (double dabble).
- Encodes each BCD digit into active-low 7-segment patterns and holds them on registered outputs until the next conversion completes.

Parameters:
- DATA_BITS, 14, width of bin_in; legal range 4..14.

Ports:
- clk  input  1  system clock (12 MHz).
- rst  input  1  reset, asynchronous, active-high.
- bin_in  input  DATA_BITS  unsigned value to display; sampled only when a start is accepted.
- start  input  1  conversion request; accepted only in IDLE.
- busy  output  1  high while a conversion is in progress (CONV or UPDATE).
- done  output  1  one-cycle pulse when digit outputs update.
- overflow  output  1  registered; high when the last accepted value was > 9999.
- digit_0_out  output  7  units digit pattern {g,f,e,d,c,b,a}, active-low.
- digit_1_out  output  7  tens digit pattern.
- digit_2_out  output  7  hundreds digit pattern.
- digit_3_out  output  7  thousands digit pattern.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, overflow=0, all digit outputs=7'b1111111 (blank). Reset mid-conversion aborts it; the partial result is discarded.
- States: IDLE, CONV, UPDATE.
- IDLE:
  - On start=1, latch bin_in into the shift register and clear the 16-bit BCD register.
  - Load bit counter=DATA_BITS.
  - Latch ovf_pending=(bin_in>9999).
  - Go to CONV.
  - start=0 keeps IDLE.
- CONV, one bit per cycle:
  - Add 3 to every BCD nibble >=5.
  - Shift {bcd,shift} left by 1 and decrement the counter.
  - After the DATA_BITS-th shift, go to UPDATE.
- UPDATE:
  - Register all four digit outputs and overflow<=ovf_pending.
  - done=1 for exactly this cycle.
  - Go to IDLE.
- Latency: start sampled at edge N; done is high in the cycle following edge N+DATA_BITS+1, with outputs valid in that same cycle. busy is high from edge N+1 until the UPDATE cycle ends.
- start while busy=1 is ignored, not queued. start held high continuously gives back-to-back conversions, one every DATA_BITS+2 cycles.
- Digit outputs change only in UPDATE and are otherwise stable, so the display never shows partial results.
- Segment encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, dash=0111111
- Overflow (value>9999, only possible when DATA_BITS=14): all four digits=dash and overflow=1. BCD carry-out beyond 16 bits is ignored.
- Value 0: digits show 0000 (see Optional Feature).
- Nibble codes 10..15 are impossible and are not required to be specially encoded; they map to blank.

Optional Feature:
- Macro BLANK_LEADING_ZEROS_EN.
- Defined: in UPDATE, digit_3..digit_1 are blanked while they and all higher digits are zero. digit_0 is always shown, so 0 displays "   0" and 105 displays " 105". Overflow dashes are unaffected.
- Undefined: all four digits are always shown, so 105 displays "0105".

Test Plan:
- Reset asserted mid-CONV (bin_in=1234) -> busy=0, done=0, overflow=0, all digits 1111111 immediately; no done pulse follows.
- start=1 one cycle, bin_in=1234, DATA_BITS=14 -> busy high 15 cycles, done at cycle 16, digits 3..0 = 1111001, 0100100, 0110000, 0011001, overflow=0.
- bin_in=9999 then 10000 -> first: four 0010000 patterns, overflow=0; second: four 0111111 dashes, overflow=1.
- bin_in=0 and bin_in=105 -> without the macro: 1000000 x4, and 1000000/1111001/1000000/0010010. With BLANK_LEADING_ZEROS_EN: digits 3..1 blank for 0; digit_3 blank for 105.
- Second start pulse two cycles after the first (during busy), with a different bin_in -> ignored; a single done with the first value's digits.
- start held high, bin_in stepping 1,2,3 -> done every 16 cycles; each result matches the value sampled at that conversion's acceptance edge.
